// File: rtl/barry_motion.sv
// ============================================================================
// Module      : barry_motion
// Description : Vertical-motion engine for the player sprite: signed velocity
//               with thrust/gravity, saturation, floor/ceiling clamping,
//               GROUND/AIR/DEAD modes, freeze and a landing pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barry_motion #(
    parameter int YW        = 9,
    parameter int TICK_MAX  = 256,
    parameter int Y_TOP     = 4,
    parameter int Y_FLOOR   = 420,
    parameter int THRUST    = 1,
    parameter int GRAV      = 1,
    parameter int VMAX_UP   = 3,
    parameter int VMAX_DOWN = 4,
    parameter int VW        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 thrust,
    input  logic                 freeze,
    input  logic                 kill,
    output logic [YW-1:0]        y,
    output logic signed [VW-1:0] vel,
    output logic [1:0]           mode,
    output logic                 on_floor,
    output logic                 on_ceiling,
    output logic                 land
);

    localparam int c_CNT_W = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
    localparam int c_VMIN_I = -VMAX_UP;

    localparam logic [1:0] c_GROUND = 2'b00;
    localparam logic [1:0] c_AIR    = 2'b01;
    localparam logic [1:0] c_DEAD   = 2'b10;

    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TICK_MAX - 1);
    localparam logic signed [VW+1:0] c_THRUST_S = THRUST[VW+1:0];
    localparam logic signed [VW+1:0] c_GRAV_S   = GRAV[VW+1:0];
    localparam logic signed [VW+1:0] c_VMIN     = c_VMIN_I[VW+1:0];
    localparam logic signed [VW+1:0] c_VMAX     = VMAX_DOWN[VW+1:0];
    localparam logic signed [YW+1:0] c_YF_S     = Y_FLOOR[YW+1:0];
    localparam logic signed [YW+1:0] c_YT_S     = Y_TOP[YW+1:0];
    localparam logic [YW-1:0]        c_YF       = Y_FLOOR[YW-1:0];
    localparam logic [YW-1:0]        c_YT       = Y_TOP[YW-1:0];

    logic [c_CNT_W-1:0]   r_cnt;
    logic [YW-1:0]        r_y;
    logic signed [VW-1:0] r_vel;
    logic [1:0]           r_mode;
    logic                 r_land;

    logic                 w_tick;
    logic                 w_thr;
    logic signed [VW+1:0] w_vraw;
    logic signed [VW+1:0] w_vsat;
    logic signed [YW+1:0] w_ysum;
    logic                 w_floor_hit;
    logic                 w_ceil_hit;
    logic [YW-1:0]        w_y_next;
    logic signed [VW-1:0] w_v_next;
    logic [1:0]           w_mode_next;

    assign w_tick = !freeze && (r_cnt == c_CNT_LAST);
    // A same-cycle kill already counts as dead for the thrust decision.
    assign w_thr  = thrust && (r_mode != c_DEAD) && !kill;

    always_comb begin
        w_vraw = w_thr ? ($signed({{2{r_vel[VW-1]}}, r_vel}) - c_THRUST_S)
                       : ($signed({{2{r_vel[VW-1]}}, r_vel}) + c_GRAV_S);
        if (w_vraw < c_VMIN) begin
            w_vsat = c_VMIN;
        end else if (w_vraw > c_VMAX) begin
            w_vsat = c_VMAX;
        end else begin
            w_vsat = w_vraw;
        end
    end

    assign w_ysum      = $signed({2'b00, r_y}) + $signed({{(YW-VW){w_vsat[VW+1]}}, w_vsat});
    assign w_floor_hit = (w_ysum >= c_YF_S);
    assign w_ceil_hit  = (w_ysum <= c_YT_S);

    always_comb begin
        w_y_next = r_y;
        w_v_next = r_vel;
        // Standing on the floor without thrust is a hold, not a fall.
        if (!((r_mode == c_GROUND) && !w_thr)) begin
            if (w_floor_hit) begin
                w_y_next = c_YF;
                w_v_next = '0;
            end else if (w_ceil_hit) begin
                w_y_next = c_YT;
                w_v_next = '0;
            end else begin
                w_y_next = w_ysum[YW-1:0];
                w_v_next = w_vsat[VW-1:0];
            end
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (kill || (r_mode == c_DEAD)) begin
            w_mode_next = c_DEAD;
        end else if (w_tick) begin
            if ((r_mode == c_AIR) && w_floor_hit) begin
                w_mode_next = c_GROUND;
            end else if ((r_mode == c_GROUND) && w_thr) begin
                w_mode_next = c_AIR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_y    <= c_YF;
            r_vel  <= '0;
            r_mode <= c_GROUND;
            r_land <= 1'b0;
        end else begin
            r_land <= 1'b0;
            r_mode <= w_mode_next;
            if (!freeze) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end
            if (w_tick) begin
                r_y    <= w_y_next;
                r_vel  <= w_v_next;
                r_land <= (r_mode == c_AIR) && !kill && w_floor_hit;
            end
        end
    end

    assign y          = r_y;
    assign vel        = r_vel;
    assign mode       = r_mode;
    assign land       = r_land;
    assign on_floor   = (r_y == c_YF);
    assign on_ceiling = (r_y == c_YT);

endmodule

`default_nettype wire

// File: tb/tb_barry_motion.sv
// ============================================================================
// Module      : tb_barry_motion
// Description : Self-checking bench for barry_motion against a behavioural
//               integer model of the motion rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barry_motion;

    localparam int YW        = 9;
    localparam int TICK_MAX  = 4;
    localparam int Y_TOP     = 4;
    localparam int Y_FLOOR   = 420;
    localparam int THRUST    = 1;
    localparam int GRAV      = 1;
    localparam int VMAX_UP   = 3;
    localparam int VMAX_DOWN = 4;
    localparam int VW        = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 thrust;
    logic                 freeze;
    logic                 kill;
    logic [YW-1:0]        y;
    logic signed [VW-1:0] vel;
    logic [1:0]           mode;
    logic                 on_floor;
    logic                 on_ceiling;
    logic                 land;

    barry_motion #(
        .YW(YW), .TICK_MAX(TICK_MAX), .Y_TOP(Y_TOP), .Y_FLOOR(Y_FLOOR),
        .THRUST(THRUST), .GRAV(GRAV), .VMAX_UP(VMAX_UP),
        .VMAX_DOWN(VMAX_DOWN), .VW(VW)
    ) u_dut (
        .clk(clk), .reset(reset), .thrust(thrust), .freeze(freeze),
        .kill(kill), .y(y), .vel(vel), .mode(mode), .on_floor(on_floor),
        .on_ceiling(on_ceiling), .land(land)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: mode 0 GROUND, 1 AIR, 2 DEAD.
    int m_y, m_v, m_mode, m_cnt, m_land;
    bit last_tick;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit rst, input bit thr, input bit frz, input bit kl);
        int  vn, ys;
        bit  et, fl;
        last_tick = 1'b0;
        m_land    = 0;
        if (rst) begin
            m_y = Y_FLOOR; m_v = 0; m_mode = 0; m_cnt = 0;
            return;
        end
        if (frz || m_cnt != TICK_MAX - 1) begin
            if (!frz) m_cnt++;
            if (kl) m_mode = 2;
            return;
        end
        m_cnt     = 0;
        last_tick = 1'b1;
        et = thr && (m_mode != 2) && !kl;
        if (m_mode == 0 && !et) begin
            if (kl) m_mode = 2;
            return;
        end
        vn = et ? m_v - THRUST : m_v + GRAV;
        if (vn < -VMAX_UP)  vn = -VMAX_UP;
        if (vn > VMAX_DOWN) vn = VMAX_DOWN;
        ys = m_y + vn;
        fl = (ys >= Y_FLOOR);
        if (fl)               begin m_y = Y_FLOOR; m_v = 0;  end
        else if (ys <= Y_TOP) begin m_y = Y_TOP;   m_v = 0;  end
        else                  begin m_y = ys;      m_v = vn; end
        if (kl || m_mode == 2)        m_mode = 2;
        else if (m_mode == 1 && fl)   begin m_mode = 0; m_land = 1; end
        else if (m_mode == 0)         m_mode = 1;
    endtask

    task automatic step(input bit rst, input bit thr, input bit frz, input bit kl);
        reset = rst; thrust = thr; freeze = frz; kill = kl;
        model_step(rst, thr, frz, kl);
        @(posedge clk);
        #1;
        check("y",          int'(y),              m_y);
        check("vel",        int'(vel),            m_v);
        check("mode",       int'(mode),           m_mode);
        check("land",       int'(land),           m_land);
        check("on_floor",   int'(on_floor),       int'(m_y == Y_FLOOR));
        check("on_ceiling", int'(on_ceiling),     int'(m_y == Y_TOP));
    endtask

    task automatic run_tick(input bit thr);
        for (int i = 0; i < TICK_MAX; i++) begin
            step(1'b0, thr, 1'b0, 1'b0);
            if (last_tick) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int up_v[4] = '{-1, -2, -3, -3};
        int up_y[4] = '{419, 417, 414, 411};
        int dn_v[8] = '{-2, -1, 0, 1, 2, 3, 4, 0};
        int dn_y[8] = '{409, 408, 408, 409, 411, 414, 418, 420};
        bit thr_r;

        reset = 1'b1; thrust = 1'b0; freeze = 1'b0; kill = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_y", int'(y), 420);
        check("rst_vel", int'(vel), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_on_floor", int'(on_floor), 1);
        check("rst_land", int'(land), 0);

        // Climb then fall back to the floor.
        for (int k = 0; k < 4; k++) begin
            run_tick(1'b1);
            check("up_vel", int'(vel), up_v[k]);
            check("up_y", int'(y), up_y[k]);
            check("up_mode", int'(mode), 1);
        end
        for (int k = 0; k < 8; k++) begin
            run_tick(1'b0);
            check("dn_vel", int'(vel), dn_v[k]);
            check("dn_y", int'(y), dn_y[k]);
            check("dn_land", int'(land), int'(k == 7));
        end
        check("landed_mode", int'(mode), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("land_one_clk", int'(land), 0);

        // Ceiling.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 200; k++) run_tick(1'b1);
        check("ceil_y", int'(y), 4);
        check("ceil_vel", int'(vel), 0);
        check("ceil_flag", int'(on_ceiling), 1);
        run_tick(1'b1);
        check("ceil_hold_y", int'(y), 4);
        check("ceil_mode", int'(mode), 1);

        // Kill mid-air with thrust held.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) run_tick(1'b1);
        check("pre_kill_y", int'(y), 411);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("kill_mode", int'(mode), 2);
        check("kill_vel", int'(vel), -3);
        for (int k = 0; k < 30; k++) begin
            run_tick(1'b1);
            if (k < 3) check("dead_vel", int'(vel), k - 2);
            check("dead_mode", int'(mode), 2);
            check("dead_land", int'(land), 0);
        end
        check("dead_floor_y", int'(y), 420);
        check("dead_floor_vel", int'(vel), 0);

        // Freeze mid-air, mid-count.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_tick(1'b1);
        run_tick(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("frz_y", int'(y), 417);
        check("frz_vel", int'(vel), -2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("frz_no_tick_yet", int'(y), 417);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("frz_resume_y", int'(y), 414);
        check("frz_resume_vel", int'(vel), -3);

        // Reset mid-flight.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_y", int'(y), 420);
        check("midrst_vel", int'(vel), 0);
        check("midrst_mode", int'(mode), 0);

        // Randomised run against the model.
        thr_r = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) thr_r = ~thr_r;
            step($urandom_range(0, 299) == 0, thr_r,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
